// File: rtl/mem_pkg.sv
// Shared memory-port types: funct3 access codes, responder FSM states, request record.
// Pure declarations; no timing or flow-control behaviour of its own.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic is_load_only(logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store byte enables/replicated data and load extraction/extension.
// Purely combinational, zero latency; no flow control.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] ld_value,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = raw_word[{addr_lo, 3'b000} +: 8];
    assign sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];

    always_comb begin
        byte_en  = 4'b0000;
        wr_word  = 32'h0;
        ld_value = 32'h0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en  = 4'b0001 << addr_lo;
                wr_word  = {4{wdata[7:0]}};
                ld_value = funct3[2] ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
                illegal  = we && is_load_only(funct3);
            end
            F3_H, F3_HU: begin
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_word  = {2{wdata[15:0]}};
                ld_value = funct3[2] ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
                misalign = addr_lo[0];
                illegal  = we && is_load_only(funct3);
            end
            F3_W: begin
                byte_en  = 4'b1111;
                wr_word  = wdata;
                ld_value = raw_word;
                misalign = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word memory slave for RV32I loads/stores; response LATENCY cycles after accept, one transaction in flight.
// req_ready only in IDLE; a response is held stable until rsp_ready, and no new request is taken until then.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    mem_state_t  state;
    mem_req_t    req_q;
    logic [3:0]  cnt;

    logic [AW-1:0] idx;
    logic [31:0]   raw_word;
    logic [3:0]    byte_en;
    logic [31:0]   wr_word;
    logic [31:0]   ld_value;
    logic          misalign;
    logic          illegal;
    logic          out_of_range;
    logic          acc_err;
    logic          commit;

    assign idx          = req_q.addr[AW+1:2];
    assign raw_word     = mem[idx];
    assign out_of_range = req_q.addr[31:2] >= 30'(DEPTH_WORDS);
    assign acc_err      = out_of_range || misalign || illegal;
    // The edge leaving WAIT is the single commit point for both store write and load sample.
    assign commit       = reset_n && (state == WAIT) && (cnt == 4'd0);

    mem_lane_align u_align (
        .funct3   (req_q.funct3),
        .addr_lo  (req_q.addr[1:0]),
        .we       (req_q.we),
        .wdata    (req_q.wdata),
        .raw_word (raw_word),
        .byte_en  (byte_en),
        .wr_word  (wr_word),
        .ld_value (ld_value),
        .misalign (misalign),
        .illegal  (illegal)
    );

    always_ff @(posedge clk) begin
        if (commit && req_q.we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
            req_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        req_q     <= '{req_we, req_addr, req_funct3, req_wdata};
                        cnt       <= 4'(LATENCY - 1);
                        state     <= WAIT;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= acc_err;
                        rsp_rdata <= (req_q.we || acc_err) ? 32'h0 : ld_value;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
